// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Constants and types shared by the rasterizer (write side) and the scanout
// engine (read side) of the 640x480 framebuffer.
//   SCR_W/SCR_H   : screen size in pixels
//   FB_AW         : framebuffer linear address width (address = SCR_W*y + x)
//   PIX_W         : pixel width, format {R[1:0],G[1:0],B[1:0]}
//   VGA_*         : default 640x480@60 porch/sync timing
//   scan_pipe_t   : per-pixel control carried through the scanout pipeline
// -----------------------------------------------------------------------------
package gpu_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int FB_AW = 19;
  localparam int PIX_W = 6;

  // Raster counter width; covers totals up to 2047.
  localparam int CNT_W = 11;

  // Width of one test-pattern colour bar.
  localparam int BAR_W = 80;

  localparam int VGA_H_FP   = 16;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BP   = 48;
  localparam int VGA_V_FP   = 10;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BP   = 33;

  // Colour field positions inside a pixel word.
  localparam int PIX_R_LSB = 4;
  localparam int PIX_G_LSB = 2;
  localparam int PIX_B_LSB = 0;

  typedef struct packed {
    logic       de;   // visible pixel
    logic       hs;   // hsync active (polarity applied at the pin)
    logic       vs;   // vsync active
    logic       tp;   // pixel comes from the test pattern
    logic [2:0] bar;  // test-pattern bar index
  } scan_pipe_t;

  function automatic logic [1:0] pix_r(input logic [PIX_W-1:0] pix);
    return pix[PIX_R_LSB +: 2];
  endfunction

  function automatic logic [1:0] pix_g(input logic [PIX_W-1:0] pix);
    return pix[PIX_G_LSB +: 2];
  endfunction

  function automatic logic [1:0] pix_b(input logic [PIX_W-1:0] pix);
    return pix[PIX_B_LSB +: 2];
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// -----------------------------------------------------------------------------
// fb_scanout_if
// Framebuffer read port between the scanout engine and the pixel memory.
//   rd_en   : read strobe (master -> slave)
//   rd_addr : linear pixel address (master -> slave)
//   rd_data : pixel, valid the cycle after rd_en (slave -> master)
// Modports: master = scanout engine, slave = framebuffer memory.
// -----------------------------------------------------------------------------
interface fb_scanout_if;

  logic                      rd_en;
  logic [gpu_pkg::FB_AW-1:0] rd_addr;
  logic [gpu_pkg::PIX_W-1:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );

endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Raster counters and stage-0 timing flags for the scanout engine.
// Ports:
//   clk, reset      : pixel clock, synchronous active-high reset
//   o_h_cnt         : current horizontal position (registered)
//   o_vis           : current position is a visible pixel
//   o_hs_act        : current position is inside hsync (active-high flag)
//   o_vs_act        : current line is inside vsync (active-high flag)
//   o_vblank        : current line is below the visible area
//   o_frame_start   : current position is (0,0)
//   o_vis_nxt       : next position is visible (for registering with counters)
//   o_fs_nxt        : next position is (0,0)
// The first cycle after reset is position (0,0): the counters hold at 0 for
// one edge after release instead of advancing, so frame_start pulses first.
// -----------------------------------------------------------------------------
module vga_timing
  import gpu_pkg::*;
#(
  parameter int H_VIS  = SCR_W,
  parameter int H_FP   = VGA_H_FP,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_BP   = VGA_H_BP,
  parameter int V_VIS  = SCR_H,
  parameter int V_FP   = VGA_V_FP,
  parameter int V_SYNC = VGA_V_SYNC,
  parameter int V_BP   = VGA_V_BP
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic             o_vis,
  output logic             o_hs_act,
  output logic             o_vs_act,
  output logic             o_vblank,
  output logic             o_frame_start,
  output logic             o_vis_nxt,
  output logic             o_fs_nxt
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic             r_run;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_vis;
  logic             r_hs_act;
  logic             r_vs_act;
  logic             r_vblank;
  logic             r_frame_start;

  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;

  // Next raster position; stays at (0,0) on the first edge after reset.
  always_comb begin
    w_h_nxt = '0;
    w_v_nxt = '0;
    if (r_run) begin
      if (r_h_cnt == H_LAST) begin
        w_h_nxt = '0;
        w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        w_h_nxt = r_h_cnt + 1'b1;
        w_v_nxt = r_v_cnt;
      end
    end
  end

  assign o_vis_nxt = (w_h_nxt < H_VIS_C) && (w_v_nxt < V_VIS_C);
  assign o_fs_nxt  = (w_h_nxt == '0) && (w_v_nxt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run         <= 1'b0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_vis         <= 1'b0;
      r_hs_act      <= 1'b0;
      r_vs_act      <= 1'b0;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_vis         <= o_vis_nxt;
      r_hs_act      <= (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
      r_vs_act      <= (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
      r_vblank      <= (w_v_nxt >= V_VIS_C);
      r_frame_start <= o_fs_nxt;
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_vis         = r_vis;
  assign o_hs_act      = r_hs_act;
  assign o_vs_act      = r_vs_act;
  assign o_vblank      = r_vblank;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/fb_scanout.sv
// -----------------------------------------------------------------------------
// fb_scanout
// Framebuffer scanout engine: walks the raster in VGA timing, reads pixels
// sequentially from the framebuffer and drives registered 2-2-2 RGB with
// hsync/vsync/de aligned to the colour (2-cycle counter-to-pin latency).
// Ports:
//   clk, reset      : pixel clock, synchronous active-high reset
//   i_test_mode     : selects the colour-bar test pattern, sampled at frame
//                     start (present only with FB_SCANOUT_TEST_PATTERN_EN)
//   fb              : framebuffer read port (fb_scanout_if.master)
//   o_red/green/blue: 2-bit colour, black outside the visible area
//   o_hsync/o_vsync : sync outputs, active level SYNC_POL
//   o_de            : data enable, aligned with colour
//   o_vblank        : vertical blanking, stage-0 timing
//   o_frame_start   : one-cycle pulse at raster position (0,0)
// Optional feature macro: FB_SCANOUT_TEST_PATTERN_EN (8 vertical colour bars).
// -----------------------------------------------------------------------------
module fb_scanout
  import gpu_pkg::*;
#(
  parameter int H_VIS    = SCR_W,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_VIS    = SCR_H,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef FB_SCANOUT_TEST_PATTERN_EN
  input  logic        i_test_mode,
`endif
  fb_scanout_if.master fb,
  output logic [1:0]  o_red,
  output logic [1:0]  o_green,
  output logic [1:0]  o_blue,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic        o_vblank,
  output logic        o_frame_start
);

  logic [CNT_W-1:0] w_h_cnt;
  logic             w_vis;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_vis_nxt;
  logic             w_fs_nxt;

  vga_timing #(
    .H_VIS  (H_VIS),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_VIS  (V_VIS),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk           (clk),
    .reset         (reset),
    .o_h_cnt       (w_h_cnt),
    .o_vis         (w_vis),
    .o_hs_act      (w_hs_act),
    .o_vs_act      (w_vs_act),
    .o_vblank      (o_vblank),
    .o_frame_start (o_frame_start),
    .o_vis_nxt     (w_vis_nxt),
    .o_fs_nxt      (w_fs_nxt)
  );

  // Test-pattern select for the current frame (w_tp_cur) and for the
  // position being loaded on this edge (w_tp_nxt).
  logic w_tp_nxt;
  logic w_tp_cur;

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic r_tp;

  // The request is latched only when the next position starts a frame, so a
  // mid-frame change never tears the picture.
  assign w_tp_nxt = w_fs_nxt ? i_test_mode : r_tp;
  assign w_tp_cur = r_tp;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tp <= 1'b0;
    end else begin
      r_tp <= w_tp_nxt;
    end
  end
`else
  assign w_tp_nxt = 1'b0;
  assign w_tp_cur = 1'b0;
`endif

  // Stage 0: read strobe and address, registered with the raster counters.
  // The address counts reads since the last frame start, so it holds through
  // blanking and restarts at 0 with every frame_start.
  logic             r_rd_en;
  logic [FB_AW-1:0] r_rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= w_vis_nxt & ~w_tp_nxt;
      if (w_fs_nxt) begin
        r_rd_addr <= '0;
      end else if (r_rd_en) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
    end
  end

  assign fb.rd_en   = r_rd_en;
  assign fb.rd_addr = r_rd_addr;

  logic [2:0] w_bar_idx;
  assign w_bar_idx = 3'(w_h_cnt / CNT_W'(BAR_W));

  // Stage 1: control travels alongside the memory read.
  scan_pipe_t r_s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
    end else begin
      r_s1.de  <= w_vis;
      r_s1.hs  <= w_hs_act;
      r_s1.vs  <= w_vs_act;
      r_s1.tp  <= w_tp_cur;
      r_s1.bar <= w_bar_idx;
    end
  end

  // Each colour channel of a bar is its index bit replicated: bar i gives
  // {i[2],i[2],i[1],i[1],i[0],i[0]}.
  logic [PIX_W-1:0] w_bar_pix;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_bar
      assign w_bar_pix[2*gi +: 2] = {2{r_s1.bar[gi]}};
    end
  endgenerate

  // rd_data is only looked at when the stage-1 pixel was actually read.
  logic [PIX_W-1:0] w_pix;

  always_comb begin
    w_pix = '0;
    if (r_s1.de) begin
      w_pix = r_s1.tp ? w_bar_pix : fb.rd_data;
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_de    <= 1'b0;
      o_hsync <= ~SYNC_POL;
      o_vsync <= ~SYNC_POL;
    end else begin
      o_red   <= pix_r(w_pix);
      o_green <= pix_g(w_pix);
      o_blue  <= pix_b(w_pix);
      o_de    <= r_s1.de;
      o_hsync <= r_s1.hs ? SYNC_POL : ~SYNC_POL;
      o_vsync <= r_s1.vs ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// -----------------------------------------------------------------------------
// tb_fb_scanout
// Bench for fb_scanout with a reduced raster (320x12 visible, 360x19 total)
// so that several frames fit in a short run. A random-filled memory answers
// reads; a raster model derived from the timing rules predicts every output
// on every cycle. Optional FB_SCANOUT_TEST_PATTERN_EN section exercises the
// colour bars.
// -----------------------------------------------------------------------------
module tb_fb_scanout;

  localparam int H_VIS  = 320;
  localparam int H_FP   = 8;
  localparam int H_SYNC = 16;
  localparam int H_BP   = 16;
  localparam int V_VIS  = 12;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int MEM_N  = H_VIS * V_VIS;

  logic       clk;
  logic       reset;
  logic       test_mode;
  logic [1:0] red, green, blue;
  logic       hsync, vsync, de, vblank, frame_start;

  fb_scanout_if fb_if ();

  fb_scanout #(
    .H_VIS    (H_VIS),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_VIS    (V_VIS),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (1'b0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    .i_test_mode   (test_mode),
`endif
    .fb            (fb_if.master),
    .o_red         (red),
    .o_green       (green),
    .o_blue        (blue),
    .o_hsync       (hsync),
    .o_vsync       (vsync),
    .o_de          (de),
    .o_vblank      (vblank),
    .o_frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] mem [MEM_N];

  int errors = 0;
  int checks = 0;
  int t = -1;          // model cycle index since reset release (-1: in reset)

  bit rst_at_edge = 1'b0;
  bit tm_at_edge  = 1'b0;
  bit armed       = 1'b0;
  bit en_q        = 1'b0;
  int a_q         = 0;

  typedef struct {
    bit vis, hs, vs, tp;
    int addr, h, v;
  } mstage_t;

  mstage_t m_cur, m_d1, m_d2;
  bit cur_tp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp);
    end
  endtask

  // Memory slave: rd_data for a cycle-N read appears during cycle N+1;
  // otherwise junk (often all-ones) that the DUT has to ignore.
  always @(posedge clk) begin
    rst_at_edge = reset;
    tm_at_edge  = test_mode;
    #1;
    if (en_q && a_q < MEM_N) fb_if.rd_data = mem[a_q];
    else if ($urandom_range(0, 2) == 0) fb_if.rd_data = 6'h3F;
    else fb_if.rd_data = 6'($urandom);
  end

  // Compare process: one pass per cycle, away from the active edge.
  always @(negedge clk) begin
    int p, h, v, er, eg, eb, ede, ehs, evs;
    logic [5:0] pix;
    if (rst_at_edge) begin
      armed = 1'b1;
      t = -1;
      en_q = 1'b0;
      m_d1 = '{default: 0};
      m_d2 = '{default: 0};
      chk("rst_rd_en", int'(fb_if.rd_en), 0);
      chk("rst_rd_addr", int'(fb_if.rd_addr), 0);
      chk("rst_de", int'(de), 0);
      chk("rst_rgb", int'({red, green, blue}), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_vblank", int'(vblank), 0);
      chk("rst_frame_start", int'(frame_start), 0);
    end else if (armed) begin
      t++;
      p = t % FRAME;
      h = p % H_TOT;
      v = p / H_TOT;
      if (p == 0) cur_tp = tm_at_edge;
      m_cur.vis  = (h < H_VIS) && (v < V_VIS);
      m_cur.hs   = (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC);
      m_cur.vs   = (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC);
      m_cur.tp   = cur_tp;
      m_cur.h    = h;
      m_cur.v    = v;
      // Reads done so far in this frame.
      if (cur_tp) m_cur.addr = 0;
      else if (v < V_VIS) m_cur.addr = v * H_VIS + ((h < H_VIS) ? h : H_VIS);
      else m_cur.addr = V_VIS * H_VIS;

      chk("rd_en", int'(fb_if.rd_en), int'(m_cur.vis && !m_cur.tp));
      chk("rd_addr", int'(fb_if.rd_addr), m_cur.addr);
      chk("frame_start", int'(frame_start), int'(p == 0));
      chk("vblank", int'(vblank), int'(v >= V_VIS));

      if (t >= 2) begin
        ede = int'(m_d2.vis);
        ehs = m_d2.hs ? 0 : 1;
        evs = m_d2.vs ? 0 : 1;
        if (!m_d2.vis) begin
          er = 0; eg = 0; eb = 0;
        end else if (m_d2.tp) begin
          er = ((m_d2.h / 80) >> 2 & 1) * 3;
          eg = ((m_d2.h / 80) >> 1 & 1) * 3;
          eb = ((m_d2.h / 80) & 1) * 3;
        end else begin
          pix = mem[m_d2.addr];
          er = int'(pix[5:4]); eg = int'(pix[3:2]); eb = int'(pix[1:0]);
        end
      end else begin
        ede = 0; ehs = 1; evs = 1; er = 0; eg = 0; eb = 0;
      end
      chk("de", int'(de), ede);
      chk("hsync", int'(hsync), ehs);
      chk("vsync", int'(vsync), evs);
      chk("red", int'(red), er);
      chk("green", int'(green), eg);
      chk("blue", int'(blue), eb);

      // Hand-computed points for the 360x19 raster.
      if (t == 0) begin
        chk("lit_fs_t0", int'(frame_start), 1);
        chk("lit_addr_t0", int'(fb_if.rd_addr), 0);
        chk("lit_rd_en_t0", int'(fb_if.rd_en), 1);
      end
      if (t == 1) chk("lit_de_t1", int'(de), 0);
      if (t == 2) chk("lit_de_t2", int'(de), 1);
      if (t == 321) chk("lit_de_t321", int'(de), 1);
      if (t == 322) chk("lit_de_t322", int'(de), 0);
      if (t == 329) chk("lit_hsync_t329", int'(hsync), 1);
      if (t == 330) chk("lit_hsync_t330", int'(hsync), 0);
      if (t == 345) chk("lit_hsync_t345", int'(hsync), 0);
      if (t == 346) chk("lit_hsync_t346", int'(hsync), 1);
      if (t == 4279) chk("lit_last_addr", int'(fb_if.rd_addr), 3839);
      if (t == 5041) chk("lit_vsync_t5041", int'(vsync), 1);
      if (t == 5042) chk("lit_vsync_t5042", int'(vsync), 0);
      if (t == 6840) begin
        chk("lit_fs_t6840", int'(frame_start), 1);
        chk("lit_addr_t6840", int'(fb_if.rd_addr), 0);
      end
`ifdef FB_SCANOUT_TEST_PATTERN_EN
      if (t >= 2 && m_d2.tp && m_d2.vis && m_d2.v == 0 && m_d2.h == 85) begin
        chk("lit_bar1_red", int'(red), 0);
        chk("lit_bar1_green", int'(green), 0);
        chk("lit_bar1_blue", int'(blue), 3);
        chk("lit_bar1_rd_en", int'(fb_if.rd_en), 0);
      end
`endif
      m_d2 = m_d1;
      m_d1 = m_cur;
      en_q = fb_if.rd_en;
      a_q  = int'(fb_if.rd_addr);
    end
  end

  // Waits (at most a bounded number of cycles) until the model reaches cycle
  // index 'target'.
  task automatic wait_t(input int target);
    int n = 0;
    while (t != target && n < 40000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (t != target) begin
      errors++;
      $display("FAIL wait_t actual=%0d required=%0d", t, target);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_mode = 1'b0;
    fb_if.rd_data = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = 6'($urandom);

    repeat (5) @(posedge clk);
    #2 reset = 1'b0;

    // Two full frames plus the start of a third.
    wait_t(2 * FRAME + 100);

    // Reset in the middle of line 5, pixel 300.
    wait_t(2 * FRAME + 5 * H_TOT + 300);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_t(FRAME + 50);

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    // Request the pattern mid-frame; takes effect at the next frame start.
    wait_t(FRAME + int'($urandom_range(1000, 5000)));
    #2 test_mode = 1'b1;
    wait_t(3 * FRAME + int'($urandom_range(200, 4000)));
    #2 test_mode = 1'b0;
    wait_t(4 * FRAME + 500);
`else
    wait_t(FRAME + 500);
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Framebuffer scanout engine for the 640x480 display path. Walks the raster in VGA timing, issues sequential reads to the pixel framebuffer that the rasterizer writes, and drives registered 2-2-2 RGB, hsync, vsync and data-enable to the DAC. It is the read side of the framebuffer: same 19-bit linear address space (`640*y + x`) and same 6-bit colour format the rasterizer writes.

## Interface
Parameters:
- `H_VIS` — default 640; visible pixels per line.
- `H_FP` — default 16; horizontal front porch.
- `H_SYNC` — default 96; hsync width.
- `H_BP` — default 48; horizontal back porch.
- `V_VIS` — default 480; visible lines.
- `V_FP` — default 10; vertical front porch.
- `V_SYNC` — default 2; vsync lines.
- `V_BP` — default 33; vertical back porch.
- `SYNC_POL` — default 0; active level of hsync/vsync.

Ports:
- `clk` — in, 1; pixel clock (25 MHz nominal).
- `reset` — in, 1; synchronous, active-high. Clock is `clk`.
- `rd_en` — out, 1; framebuffer read strobe.
- `rd_addr` — out, 19; linear pixel address.
- `rd_data` — in, 6; pixel returned one cycle after `rd_en`, format `{R[1:0],G[1:0],B[1:0]}`.
- `red`, `green`, `blue` — out, 2 each; colour outputs.
- `hsync`, `vsync` — out, 1; sync outputs at `SYNC_POL`.
- `de` — out, 1; data enable (visible pixel).
- `vblank` — out, 1; high while `v_cnt >= V_VIS` (stage-0 timing, unpipelined). The GPU uses it for tear-free updates.
- `frame_start` — out, 1; one-cycle pulse when `h_cnt==0 && v_cnt==0`.

## Operation
- **Stage 0 counters.**
  - `h_cnt` counts 0..H_TOT-1, where H_TOT = sum of the H params (800).
  - `v_cnt` counts 0..V_TOT-1 (525). It increments when `h_cnt` wraps.
  - Both wrap to 0. The frame wrap happens at `h_cnt==799 && v_cnt==524`.
- **Visible region.** `vis = h_cnt < H_VIS && v_cnt < V_VIS`.
  - `rd_en = vis`, registered with the counters.
  - `rd_addr` is an incrementing counter, not a multiply. It advances by 1 after each `rd_en` cycle.
  - It is forced to 0 when `frame_start` is asserted, so it wraps 307199 -> 0 at frame end.
  - It holds its value during blanking.
- **Sync generation.**
  - hsync is active while H_VIS+H_FP <= `h_cnt` < H_VIS+H_FP+H_SYNC (656..751).
  - vsync is active while V_VIS+V_FP <= `v_cnt` < V_VIS+V_FP+V_SYNC (490..491).
  - Inactive level is `!SYNC_POL`.
- **Pipeline.** Stage 1 is the RAM read. Stage 2 is the output registers. `hsync`, `vsync` and `de` are delayed through two registers so they align with colour.
- **Colour output.**
  - When delayed `de` is 1: `red=rd_data[5:4]`, `green=[3:2]`, `blue=[1:0]`.
  - Otherwise colour is forced to 0 (blanking must be black).
- **Reset values.** `rd_en=0`, `rd_addr=0`, `de=0`, rgb=0, `hsync=vsync=!SYNC_POL`, `vblank=0`, `frame_start=0`. Counters and pipeline registers are 0.
- **First frame.** The first cycle after reset deassert is `h_cnt=0`, `v_cnt=0`, and `frame_start` pulses.
- **Reset mid-frame.** Reset aborts immediately. Pipeline contents are discarded, and the next frame starts from address 0.

## Timing
- Latency from counter to pin is 2 cycles for colour, `de` and syncs alike.
- `rd_en`/`rd_addr` in cycle N, `rd_data` valid in N+1, and colour on the pins in N+2.
- `de` is high for 640 consecutive cycles per visible line and for 480 lines per frame.
- Frame period is 420000 cycles.
- `rd_data` is sampled only in the cycle after `rd_en`; otherwise it is ignored.

## Configuration
- Macro `FB_SCANOUT_TEST_PATTERN_EN`.
- **Defined:**
  - Adds input `test_mode` (1 bit), sampled only at `frame_start`.
  - While the latched value is 1: `rd_en` is held 0, and colour comes from 8 vertical bars, each 80 px wide.
  - Bar index `i = h_cnt/80`; colour = `{i[2],i[2],i[1],i[1],i[0],i[0]}`. The colour is delayed 2 cycles like memory data.
  - Sync timing is unchanged.
- **Undefined:** the port is absent and output is always from the framebuffer.

## Structure
- Shared package `gpu_pkg`:
  - Screen constants `SCR_W=640`, `SCR_H=480`, `FB_AW=19`, `PIX_W=6`.
  - Colour field slices.
  - Default VGA timing constants. The rasterizer reuses `SCR_W` for its address computation.
- Sub-module `vga_timing`: counters, sync, `vis`, `vblank`, `frame_start`.
- `fb_scanout` contains addressing, the pipeline and the colour mux.

## Test plan
- **Reset value check:**
  - Hold reset 5 cycles -> all outputs at reset values. `hsync=vsync=1` with `SYNC_POL=0`.
- **First line:**
  - Release reset -> `rd_en` is high for cycles 0..639 with `rd_addr` 0..639.
  - `de` is high on cycles 2..641.
  - With `rd_data=rd_addr[5:0]` one cycle later, the pins show the matching RGB.
- **Horizontal sync:**
  - `hsync` is low on cycles 658..753 of each line.
  - Blanking RGB is 0 even if `rd_data=6'h3F`.
- **Full frame:**
  - The last read of the frame is at `rd_addr=307199`, and the next `frame_start` occurs at cycle 420000.
  - `rd_addr=0` on the next visible pixel.
  - `vsync` is low for exactly lines 490..491 (offset 2 cycles).
- **Reset mid-line:**
  - Assert reset at line 100 with `h_cnt=300` -> outputs return to reset values the next cycle.
  - After release, `rd_addr` restarts at 0 and `frame_start` pulses.
- **Test pattern** (`FB_SCANOUT_TEST_PATTERN_EN`):
  - Raise `test_mode` mid-frame -> no change until the next `frame_start`.
  - Then `rd_en=0` and pixel 85 of line 0 shows bar 1 = `{R=0,G=0,B=3}`.
